// File: rtl/video_timing_pkg.sv
// ============================================================================
// Module      : video_timing_pkg
// Description : Default 640x480@60 raster timing, total helpers, coord type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package video_timing_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_COORD_W   = 10;
  localparam int DEF_FRAME_W   = 8;

  typedef logic [DEF_COORD_W-1:0] coord_t;

  function automatic int h_total(input int vis, input int fp, input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

  function automatic int v_total(input int vis, input int fp, input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pix_tick_div.sv
// ============================================================================
// Module      : pix_tick_div
// Description : Divides clk into a one-cycle pixel enable every CLK_DIV cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pix_tick_div
  import video_timing_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int               CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == c_last) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Masked by reset so a divide-by-one enable stays low while reset is held.
  assign p_tick = (cnt_q == c_last) && !reset;

endmodule

`default_nettype wire

// File: rtl/video_timing_gen.sv
// ============================================================================
// Module      : video_timing_gen
// Description : Parametrised raster timing generator (sync, blanking, strobes).
//               Optional macro VIDEO_TIMING_LOOKAHEAD_EN adds next-position ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int COORD_W   = DEF_COORD_W,
  parameter int FRAME_W   = DEF_FRAME_W
) (
  input  logic               clk,
  input  logic               reset,
  output logic               p_tick,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
`ifdef VIDEO_TIMING_LOOKAHEAD_EN
  ,
  output logic [COORD_W-1:0] x_next,
  output logic [COORD_W-1:0] y_next,
  output logic               video_on_next
`endif
);

  localparam int H_TOTAL = h_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

  generate
    if (CLK_DIV < 1 || H_VISIBLE < 1 || H_SYNC < 1 || V_VISIBLE < 1 || V_SYNC < 1 ||
        H_FP < 0 || H_BP < 0 || V_FP < 0 || V_BP < 0 || COORD_W < 1 || FRAME_W < 1 ||
        H_TOTAL > (2 ** COORD_W) || V_TOTAL > (2 ** COORD_W)) begin : g_param_check
      $error("video_timing_gen: illegal timing parameters");
    end
  endgenerate

  // One extra bit keeps boundaries equal to 2**COORD_W representable.
  localparam logic [COORD_W:0] c_h_vis    = (COORD_W+1)'(H_VISIBLE);
  localparam logic [COORD_W:0] c_h_hs_beg = (COORD_W+1)'(H_VISIBLE + H_FP);
  localparam logic [COORD_W:0] c_h_hs_end = (COORD_W+1)'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [COORD_W:0] c_v_vis    = (COORD_W+1)'(V_VISIBLE);
  localparam logic [COORD_W:0] c_v_vs_beg = (COORD_W+1)'(V_VISIBLE + V_FP);
  localparam logic [COORD_W:0] c_v_vs_end = (COORD_W+1)'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [COORD_W-1:0] c_h_last = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] c_v_last = COORD_W'(V_TOTAL - 1);

  logic               w_tick;
  logic               w_h_last;
  logic               w_v_last;
  logic [COORD_W:0]   w_x_ext;
  logic [COORD_W:0]   w_y_ext;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] x_d;
  logic [COORD_W-1:0] y_q;
  logic [COORD_W-1:0] y_d;
  logic [FRAME_W-1:0] fcnt_q;
  logic [FRAME_W-1:0] fcnt_d;

  pix_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick_div (
    .clk    (clk),
    .reset  (reset),
    .p_tick (w_tick)
  );

  assign w_h_last = (x_q == c_h_last);
  assign w_v_last = (y_q == c_v_last);

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    fcnt_d = fcnt_q;
    if (w_tick) begin
      if (w_h_last) begin
        x_d = '0;
        if (w_v_last) begin
          y_d    = '0;
          fcnt_d = fcnt_q + FRAME_W'(1);
        end else begin
          y_d = y_q + COORD_W'(1);
        end
      end else begin
        x_d = x_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      fcnt_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign w_x_ext     = {1'b0, x_q};
  assign w_y_ext     = {1'b0, y_q};

  assign p_tick      = w_tick;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_cnt   = fcnt_q;
  assign video_on    = (w_x_ext < c_h_vis) && (w_y_ext < c_v_vis);
  assign hsync       = ((w_x_ext >= c_h_hs_beg) && (w_x_ext < c_h_hs_end)) ? HSYNC_POL : ~HSYNC_POL;
  assign vsync       = ((w_y_ext >= c_v_vs_beg) && (w_y_ext < c_v_vs_end)) ? VSYNC_POL : ~VSYNC_POL;
  assign line_start  = w_tick && (x_q == '0);
  assign frame_start = w_tick && (x_q == '0) && (y_q == '0);

`ifdef VIDEO_TIMING_LOOKAHEAD_EN
  logic [COORD_W-1:0] w_x_nxt;
  logic [COORD_W-1:0] w_y_nxt;

  // Position after the next tick, independent of whether this cycle ticks.
  always_comb begin
    w_x_nxt = x_q + COORD_W'(1);
    w_y_nxt = y_q;
    if (w_h_last) begin
      w_x_nxt = '0;
      w_y_nxt = w_v_last ? '0 : y_q + COORD_W'(1);
    end
  end

  assign x_next        = w_x_nxt;
  assign y_next        = w_y_nxt;
  assign video_on_next = ({1'b0, w_x_nxt} < c_h_vis) && ({1'b0, w_y_nxt} < c_v_vis);
`endif

endmodule

`default_nettype wire

// File: tb/tb_video_timing_gen.sv
// ============================================================================
// Module      : tb_video_timing_gen
// Description : Randomised self-checking bench for two small raster configs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_video_timing_gen;

  // Instance A: slow divider, tiny frame, narrow frame counter.
  localparam int A_DIV = 3, A_HV = 8, A_HFP = 2, A_HS = 3, A_HBP = 2;
  localparam int A_VV = 5, A_VFP = 1, A_VS = 2, A_VBP = 1, A_CW = 4, A_FW = 2;
  localparam bit A_HPOL = 1'b1, A_VPOL = 1'b0;
  // Instance B: divide-by-one, 7x6 frame.
  localparam int B_DIV = 1, B_HV = 4, B_HFP = 1, B_HS = 1, B_HBP = 1;
  localparam int B_VV = 3, B_VFP = 1, B_VS = 1, B_VBP = 1, B_CW = 3, B_FW = 3;
  localparam bit B_HPOL = 1'b1, B_VPOL = 1'b0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic            pA, hsA, vsA, vonA, lsA, fsA;
  logic [A_CW-1:0] xA, yA;
  logic [A_FW-1:0] fcA;
  logic            pB, hsB, vsB, vonB, lsB, fsB;
  logic [B_CW-1:0] xB, yB;
  logic [B_FW-1:0] fcB;
`ifdef VIDEO_TIMING_LOOKAHEAD_EN
  logic [A_CW-1:0] xnA, ynA;
  logic [B_CW-1:0] xnB, ynB;
  logic            vonnA, vonnB;
`endif

  video_timing_gen #(
    .H_VISIBLE(A_HV), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
    .V_VISIBLE(A_VV), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
    .HSYNC_POL(A_HPOL), .VSYNC_POL(A_VPOL), .CLK_DIV(A_DIV),
    .COORD_W(A_CW), .FRAME_W(A_FW)
  ) u_dut_a (
    .clk(clk), .reset(reset), .p_tick(pA), .x(xA), .y(yA), .hsync(hsA), .vsync(vsA),
    .video_on(vonA), .line_start(lsA), .frame_start(fsA), .frame_cnt(fcA)
`ifdef VIDEO_TIMING_LOOKAHEAD_EN
    , .x_next(xnA), .y_next(ynA), .video_on_next(vonnA)
`endif
  );

  video_timing_gen #(
    .H_VISIBLE(B_HV), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_VISIBLE(B_VV), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
    .HSYNC_POL(B_HPOL), .VSYNC_POL(B_VPOL), .CLK_DIV(B_DIV),
    .COORD_W(B_CW), .FRAME_W(B_FW)
  ) u_dut_b (
    .clk(clk), .reset(reset), .p_tick(pB), .x(xB), .y(yB), .hsync(hsB), .vsync(vsB),
    .video_on(vonB), .line_start(lsB), .frame_start(fsB), .frame_cnt(fcB)
`ifdef VIDEO_TIMING_LOOKAHEAD_EN
    , .x_next(xnB), .y_next(ynB), .video_on_next(vonnB)
`endif
  );

  int checks = 0;
  int errors = 0;
  // k = 0 while reset is held; otherwise 1-based cycle count since the last reset edge.
  int k = 0;

  typedef struct {
    bit tick; int x; int y; int fc;
    bit von; bit hs; bit vs; bit ls; bit fs;
    int xn; int yn; bit vonn;
  } exp_t;

  // Reference: position is simply (tick count) mod frame size, split into x/y.
  function automatic exp_t model(input int div, input int hv, input int hfp, input int hs,
                                 input int hbp, input int vv, input int vfp, input int vs,
                                 input int vbp, input bit hpol, input bit vpol, input int fw,
                                 input int cyc, input bit rst_now);
    exp_t e;
    int ht, vt, t, n, n2;
    ht = hv + hfp + hs + hbp;
    vt = vv + vfp + vs + vbp;
    t  = (cyc == 0) ? 0 : (cyc - 1) / div;
    e.tick = (cyc != 0) && !rst_now && ((cyc % div) == 0);
    n    = t % (ht * vt);
    e.x  = n % ht;
    e.y  = n / ht;
    e.fc = (t / (ht * vt)) % (1 << fw);
    e.von = (e.x < hv) && (e.y < vv);
    e.hs  = (e.x >= hv + hfp && e.x < hv + hfp + hs) ? hpol : !hpol;
    e.vs  = (e.y >= vv + vfp && e.y < vv + vfp + vs) ? vpol : !vpol;
    e.ls  = e.tick && (e.x == 0);
    e.fs  = e.tick && (n == 0);
    n2   = (n + 1) % (ht * vt);
    e.xn = n2 % ht;
    e.yn = n2 / ht;
    e.vonn = (e.xn < hv) && (e.yn < vv);
    return e;
  endfunction

  // Drive reset for the next edge, advance the cycle model, land on the negedge.
  task automatic step(input bit rst_next);
    bit sampled;
    @(posedge clk);
    sampled = reset;
    #1 reset = rst_next;
    if (sampled) k = rst_next ? 0 : 1;
    else         k = k + 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(1'b1); step(1'b1); step(1'b1);
    checks += 18;
    if (pA !== 1'b0)   begin errors++; $display("FAIL rst_ptick_a got %b want 0", pA); end
    if (xA !== '0)     begin errors++; $display("FAIL rst_x_a got %0d want 0", xA); end
    if (yA !== '0)     begin errors++; $display("FAIL rst_y_a got %0d want 0", yA); end
    if (fcA !== '0)    begin errors++; $display("FAIL rst_fc_a got %0d want 0", fcA); end
    if (vonA !== 1'b1) begin errors++; $display("FAIL rst_von_a got %b want 1", vonA); end
    if (hsA !== !A_HPOL) begin errors++; $display("FAIL rst_hs_a got %b want %b", hsA, !A_HPOL); end
    if (vsA !== !A_VPOL) begin errors++; $display("FAIL rst_vs_a got %b want %b", vsA, !A_VPOL); end
    if (lsA !== 1'b0)  begin errors++; $display("FAIL rst_ls_a got %b want 0", lsA); end
    if (fsA !== 1'b0)  begin errors++; $display("FAIL rst_fs_a got %b want 0", fsA); end
    if (pB !== 1'b0)   begin errors++; $display("FAIL rst_ptick_b got %b want 0", pB); end
    if (xB !== '0)     begin errors++; $display("FAIL rst_x_b got %0d want 0", xB); end
    if (yB !== '0)     begin errors++; $display("FAIL rst_y_b got %0d want 0", yB); end
    if (fcB !== '0)    begin errors++; $display("FAIL rst_fc_b got %0d want 0", fcB); end
    if (vonB !== 1'b1) begin errors++; $display("FAIL rst_von_b got %b want 1", vonB); end
    if (hsB !== !B_HPOL) begin errors++; $display("FAIL rst_hs_b got %b want %b", hsB, !B_HPOL); end
    if (vsB !== !B_VPOL) begin errors++; $display("FAIL rst_vs_b got %b want %b", vsB, !B_VPOL); end
    if (lsB !== 1'b0)  begin errors++; $display("FAIL rst_ls_b got %b want 0", lsB); end
    if (fsB !== 1'b0)  begin errors++; $display("FAIL rst_fs_b got %b want 0", fsB); end
  endtask

  task automatic test_random_run(input int n_cycles);
    exp_t ea, eb;
    bit   rn;
    for (int i = 0; i < n_cycles; i++) begin
      rn = (i > 0) && ($urandom_range(0, 399) == 0);
      step(rn);
      ea = model(A_DIV, A_HV, A_HFP, A_HS, A_HBP, A_VV, A_VFP, A_VS, A_VBP, A_HPOL, A_VPOL, A_FW, k, reset);
      eb = model(B_DIV, B_HV, B_HFP, B_HS, B_HBP, B_VV, B_VFP, B_VS, B_VBP, B_HPOL, B_VPOL, B_FW, k, reset);
      checks += 18;
      if (pA !== ea.tick) begin errors++; $display("FAIL run_ptick_a k=%0d got %b want %b", k, pA, ea.tick); end
      if (int'(xA) !== ea.x) begin errors++; $display("FAIL run_x_a k=%0d got %0d want %0d", k, xA, ea.x); end
      if (int'(yA) !== ea.y) begin errors++; $display("FAIL run_y_a k=%0d got %0d want %0d", k, yA, ea.y); end
      if (int'(fcA) !== ea.fc) begin errors++; $display("FAIL run_fc_a k=%0d got %0d want %0d", k, fcA, ea.fc); end
      if (vonA !== ea.von) begin errors++; $display("FAIL run_von_a k=%0d got %b want %b", k, vonA, ea.von); end
      if (hsA !== ea.hs) begin errors++; $display("FAIL run_hs_a k=%0d got %b want %b", k, hsA, ea.hs); end
      if (vsA !== ea.vs) begin errors++; $display("FAIL run_vs_a k=%0d got %b want %b", k, vsA, ea.vs); end
      if (lsA !== ea.ls) begin errors++; $display("FAIL run_ls_a k=%0d got %b want %b", k, lsA, ea.ls); end
      if (fsA !== ea.fs) begin errors++; $display("FAIL run_fs_a k=%0d got %b want %b", k, fsA, ea.fs); end
      if (pB !== eb.tick) begin errors++; $display("FAIL run_ptick_b k=%0d got %b want %b", k, pB, eb.tick); end
      if (int'(xB) !== eb.x) begin errors++; $display("FAIL run_x_b k=%0d got %0d want %0d", k, xB, eb.x); end
      if (int'(yB) !== eb.y) begin errors++; $display("FAIL run_y_b k=%0d got %0d want %0d", k, yB, eb.y); end
      if (int'(fcB) !== eb.fc) begin errors++; $display("FAIL run_fc_b k=%0d got %0d want %0d", k, fcB, eb.fc); end
      if (vonB !== eb.von) begin errors++; $display("FAIL run_von_b k=%0d got %b want %b", k, vonB, eb.von); end
      if (hsB !== eb.hs) begin errors++; $display("FAIL run_hs_b k=%0d got %b want %b", k, hsB, eb.hs); end
      if (vsB !== eb.vs) begin errors++; $display("FAIL run_vs_b k=%0d got %b want %b", k, vsB, eb.vs); end
      if (lsB !== eb.ls) begin errors++; $display("FAIL run_ls_b k=%0d got %b want %b", k, lsB, eb.ls); end
      if (fsB !== eb.fs) begin errors++; $display("FAIL run_fs_b k=%0d got %b want %b", k, fsB, eb.fs); end
`ifdef VIDEO_TIMING_LOOKAHEAD_EN
      checks += 6;
      if (int'(xnA) !== ea.xn) begin errors++; $display("FAIL run_xn_a got %0d want %0d", xnA, ea.xn); end
      if (int'(ynA) !== ea.yn) begin errors++; $display("FAIL run_yn_a got %0d want %0d", ynA, ea.yn); end
      if (vonnA !== ea.vonn) begin errors++; $display("FAIL run_vonn_a got %b want %b", vonnA, ea.vonn); end
      if (int'(xnB) !== eb.xn) begin errors++; $display("FAIL run_xn_b got %0d want %0d", xnB, eb.xn); end
      if (int'(ynB) !== eb.yn) begin errors++; $display("FAIL run_yn_b got %0d want %0d", ynB, eb.yn); end
      if (vonnB !== eb.vonn) begin errors++; $display("FAIL run_vonn_b got %b want %b", vonnB, eb.vonn); end
`endif
    end
  endtask

  task automatic test_mid_reset();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < int'($urandom_range(150, 700)); i++) step(1'b0);
      step(1'b1);
      step(1'b0);
      checks += 6;
      if (pA !== 1'b0) begin errors++; $display("FAIL mid_ptick got %b want 0", pA); end
      if (xA !== '0)   begin errors++; $display("FAIL mid_x got %0d want 0", xA); end
      if (yA !== '0)   begin errors++; $display("FAIL mid_y got %0d want 0", yA); end
      if (fcA !== '0)  begin errors++; $display("FAIL mid_fc got %0d want 0", fcA); end
      if (hsA !== !A_HPOL) begin errors++; $display("FAIL mid_hs got %b want %b", hsA, !A_HPOL); end
      if (vsA !== !A_VPOL) begin errors++; $display("FAIL mid_vs got %b want %b", vsA, !A_VPOL); end
    end
  endtask

  task automatic test_frame_wrap();
    int exp_seq [6];
    int got_seq [6];
    int at_cyc  [6];
    int found = 0;
    int frame_cycles;
    exp_seq = '{0, 1, 2, 3, 0, 1};
    frame_cycles = A_DIV * (A_HV + A_HFP + A_HS + A_HBP) * (A_VV + A_VFP + A_VS + A_VBP);
    step(1'b1); step(1'b0);
    for (int c = 0; c < 3000 && found < 6; c++) begin
      if (fsA === 1'b1) begin
        got_seq[found] = int'(fcA);
        at_cyc[found]  = k;
        found++;
      end
      if (found < 6) step(1'b0);
    end
    checks++;
    if (found != 6) begin errors++; $display("FAIL wrap_count got %0d frame_starts want 6", found); end
    checks++;
    if (found > 0 && at_cyc[0] != A_DIV) begin errors++; $display("FAIL first_fs got cycle %0d want %0d", at_cyc[0], A_DIV); end
    for (int i = 0; i < found; i++) begin
      checks++;
      if (got_seq[i] != exp_seq[i]) begin errors++; $display("FAIL wrap_fc[%0d] got %0d want %0d", i, got_seq[i], exp_seq[i]); end
      if (i > 0) begin
        checks++;
        if (at_cyc[i] - at_cyc[i-1] != frame_cycles) begin
          errors++; $display("FAIL fs_spacing[%0d] got %0d want %0d", i, at_cyc[i] - at_cyc[i-1], frame_cycles);
        end
      end
    end
  endtask

  task automatic test_frame_stats();
    int von_n = 0, hs_n = 0, vs_n = 0, ticks = 0;
    bit seen = 1'b0;
    step(1'b1); step(1'b0);
    for (int c = 0; c < 100 && !seen; c++) begin
      if (fsB === 1'b1) seen = 1'b1;
      else step(1'b0);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL stats_fs_timeout got none want frame_start"); end
    for (int i = 0; i < 42; i++) begin
      if (pB === 1'b1) begin
        ticks++;
        if (vonB === 1'b1) von_n++;
        if (hsB === 1'b1) hs_n++;
        if (vsB === 1'b0) vs_n++;
      end
      step(1'b0);
    end
    checks += 5;
    if (ticks != 42) begin errors++; $display("FAIL stats_ticks got %0d want 42", ticks); end
    if (von_n != 12) begin errors++; $display("FAIL stats_video_on got %0d want 12", von_n); end
    if (hs_n != 6)   begin errors++; $display("FAIL stats_hsync got %0d want 6", hs_n); end
    if (vs_n != 7)   begin errors++; $display("FAIL stats_vsync got %0d want 7", vs_n); end
    if (fsB !== 1'b1) begin errors++; $display("FAIL stats_next_fs got %b want 1", fsB); end
  endtask

  initial begin
    test_reset();
    test_random_run(2500);
    test_mid_reset();
    test_frame_wrap();
    test_frame_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for StarSoC display output, generalising the fixed 640x480@60 Hz timing block. It divides the system clock into a pixel-rate enable, walks a horizontal/vertical position counter over a fully parametrised frame, and produces sync, blanking, coordinate, line/frame strobes and a frame counter. It sits between the clock source and the pixel/sprite pipeline and HDMI encoder.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync
- CLK_DIV, 2, clk cycles per pixel (>= 1)
- COORD_W, 10, width of x/y
- FRAME_W, 8, width of frame_cnt
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- p_tick  output  1  pixel enable, one clk cycle wide, every CLK_DIV cycles
- x  output  COORD_W  current horizontal position, 0..H_TOTAL-1
- y  output  COORD_W  current vertical position, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, polarity per HSYNC_POL
- vsync  output  1  vertical sync, polarity per VSYNC_POL
- video_on  output  1  current position in visible area
- line_start  output  1  p_tick && x == 0
- frame_start  output  1  p_tick && x == 0 && y == 0
- frame_cnt  output  FRAME_W  completed-frame count, wrapping

## Operation
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Divider counts 0..CLK_DIV-1 on every clk; p_tick high in the cycle the divider equals CLK_DIV-1. CLK_DIV = 1: p_tick constantly high after reset.
- On a clk edge with p_tick high: x increments; at x == H_TOTAL-1, x -> 0 and y increments; at (H_TOTAL-1, V_TOTAL-1), x, y -> 0 and frame_cnt increments modulo 2^FRAME_W.
- Without p_tick, x/y/frame_cnt hold.
- video_on = (x < H_VISIBLE) && (y < V_VISIBLE).
- hsync active for H_VISIBLE+H_FP <= x < H_VISIBLE+H_FP+H_SYNC; vsync active for V_VISIBLE+V_FP <= y < V_VISIBLE+V_FP+V_SYNC; inactive level = inverse of polarity parameter.
- Strobes are qualified by p_tick: consumers sample position on p_tick cycles only.
- Elaboration error if CLK_DIV < 1, any timing parameter is 0 (except porches, which may be 0), or H_TOTAL/V_TOTAL exceeds 2^COORD_W.

## Timing
- Reset values (after first reset edge): divider 0, p_tick 0, x 0, y 0, frame_cnt 0, video_on 1, hsync/vsync inactive, line_start 0, frame_start 0.
- First p_tick in the CLK_DIV-th cycle after reset deasserts; frame_start asserts with it (position (0,0)).
- All outputs are decodes of registered state; x/y update on the edge ending a p_tick cycle; decoded outputs valid in the same cycle as the new x/y (zero extra latency).
- Reset mid-frame: all state returns to reset values at the next edge regardless of p_tick; no partial-frame frame_cnt increment.
- Simultaneous line wrap and frame wrap: single edge, frame_start on the following tick at (0,0).

## Configuration
- VIDEO_TIMING_LOOKAHEAD_EN defined: adds outputs x_next, y_next (COORD_W) and video_on_next, giving the position that x/y will take after the next p_tick, including wrap; lets framebuffer/sprite ROM fetches with one pixel of latency align to video_on. Reset values: 1, 0, 1.
- Not defined: ports and logic absent; all other behaviour identical.

## Structure
- video_timing_pkg: default 640x480@60 timing localparams, derived H_TOTAL/V_TOTAL functions, coord_t typedef (logic [COORD_W-1:0] default 10).
- Sub-module pix_tick_div: parametrised CLK_DIV enable divider with synchronous reset; instantiated once.

## Test plan
- Defaults, release reset -> p_tick every 2nd clk; first frame_start 2 cycles after release; x reaches 799 then 0 with y 0 -> 1.
- Defaults, run one full frame -> 800*525 = 420000 p_ticks between frame_starts; frame_cnt 0 -> 1; hsync low exactly for x 656..751, vsync low exactly for y 490..491.
- CLK_DIV=1, H 4/1/1/1, V 3/1/1/1, HSYNC_POL=1 -> p_tick constant; x cycles 0..6; hsync high only at x=5; video_on count 12 per 42-tick frame.
- FRAME_W=2, run 5 frames -> frame_cnt sequence 0,1,2,3,0,1.
- Assert reset at x=400, y=300 for one edge -> next cycle x=0, y=0, frame_cnt=0, p_tick=0, hsync/vsync inactive.
- With VIDEO_TIMING_LOOKAHEAD_EN, at (799,524) -> x_next=0, y_next=0, video_on_next=1; at (639,0) -> x_next=640, video_on_next=0.
